// File: rtl/tx_frame_sequencer.sv
// 802.11a DATA-field sequencer: computes N_SYM/pad count for a RATE/LENGTH request and
// streams SERVICE, PSDU (LSB first), TAIL and PAD bits into the transmitter one per cycle.
module tx_frame_sequencer #(
    parameter int unsigned LEN_W = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start_Frame,
    input  logic [3:0]       Rate,
    input  logic [LEN_W-1:0] Length,
    input  logic [7:0]       Data_In,
    input  logic             Data_Valid,
    output logic             Data_Ready,
    output logic             Tx_Start,
    output logic             Tx_x,
    output logic [7:0]       Num_Pads,
    output logic [LEN_W-1:0] N_Sym,
    output logic             Busy,
    output logic             Done,
    output logic             Rate_Err,
    output logic             Underrun
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_SERVICE = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_TAIL    = 3'd4;
    localparam logic [2:0] S_PAD     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [7:0]       ndbps_q, ndbps_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      tgt_q, tgt_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] n_q, n_d;
    logic [LEN_W-1:0] n_sym_q, n_sym_d;
    logic [7:0]       num_pads_q, num_pads_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       byte_buf_q, byte_buf_d;
    logic             buf_full_q, buf_full_d;
    logic [LEN_W-1:0] fetched_q, fetched_d;
    logic             tx_start_q, tx_start_d;
    logic             tx_x_q, tx_x_d;
    logic             done_q, done_d;
    logic             rate_err_q, rate_err_d;
    logic             underrun_q, underrun_d;

    logic [7:0]  rate_dbps;
    logic [15:0] acc_sum;
    logic        load_due;
    logic        fetch_state;
    logic        xfer;

    always_comb begin
        case (Rate)
            4'b1101: rate_dbps = 8'd24;
            4'b1111: rate_dbps = 8'd36;
            4'b0101: rate_dbps = 8'd48;
            4'b0111: rate_dbps = 8'd72;
            4'b1001: rate_dbps = 8'd96;
            4'b1011: rate_dbps = 8'd144;
            4'b0001: rate_dbps = 8'd192;
            4'b0011: rate_dbps = 8'd216;
            default: rate_dbps = 8'd0;
        endcase
    end

    assign acc_sum     = acc_q + 16'(ndbps_q);
    // A byte is due at the last SERVICE bit edge and after every 8th DATA bit, except the final one.
    assign load_due    = ((state_q == S_SERVICE) && (cnt_q == 16'd1)) ||
                         ((state_q == S_DATA) && (bit_idx_q == 3'd7) && (cnt_q != 16'd1));
    assign fetch_state = (state_q == S_CALC) || (state_q == S_SERVICE) || (state_q == S_DATA);
    assign Data_Ready  = (!buf_full_q || load_due) && fetch_state && (fetched_q < len_q);
    assign xfer        = Data_Valid && Data_Ready;

    always_comb begin
        state_d    = state_q;
        ndbps_d    = ndbps_q;
        len_d      = len_q;
        tgt_d      = tgt_q;
        acc_d      = acc_q;
        n_d        = n_q;
        n_sym_d    = n_sym_q;
        num_pads_d = num_pads_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        sh_d       = sh_q;
        byte_buf_d = byte_buf_q;
        buf_full_d = buf_full_q;
        fetched_d  = fetched_q;
        tx_start_d = 1'b0;
        tx_x_d     = 1'b0;
        done_d     = 1'b0;
        rate_err_d = 1'b0;
        underrun_d = 1'b0;

        if (xfer) begin
            byte_buf_d = Data_In;
            buf_full_d = 1'b1;
            fetched_d  = fetched_q + LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (Start_Frame) begin
                    if ((rate_dbps != 8'd0) && (Length != '0)) begin
                        state_d    = S_CALC;
                        ndbps_d    = rate_dbps;
                        len_d      = Length;
                        tgt_d      = 16'd22 + 16'({Length, 3'b000});
                        acc_d      = '0;
                        n_d        = '0;
                        fetched_d  = '0;
                        buf_full_d = 1'b0;
                    end else begin
                        rate_err_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_sum;
                n_d   = n_q + LEN_W'(1);
                if (acc_sum >= tgt_q) begin
                    n_sym_d    = n_q + LEN_W'(1);
                    num_pads_d = 8'(acc_sum - tgt_q);
                    state_d    = S_SERVICE;
                    cnt_d      = 16'd16;
                    tx_start_d = 1'b1;
                end
            end
            S_SERVICE, S_DATA: begin
                tx_start_d = 1'b1;
                if (load_due) begin
                    if (buf_full_q) begin
                        tx_x_d     = byte_buf_q[0];
                        sh_d       = {1'b0, byte_buf_q[7:1]};
                        buf_full_d = xfer;
                        bit_idx_d  = '0;
                        if (state_q == S_SERVICE) begin
                            state_d = S_DATA;
                            cnt_d   = 16'({len_q, 3'b000});
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end else begin
                        state_d    = S_IDLE;
                        tx_start_d = 1'b0;
                        underrun_d = 1'b1;
                        buf_full_d = 1'b0;
                    end
                end else if (cnt_q == 16'd1) begin
                    state_d = S_TAIL;
                    cnt_d   = 16'd6;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                    if (state_q == S_DATA) begin
                        tx_x_d    = sh_q[0];
                        sh_d      = {1'b0, sh_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_TAIL: begin
                tx_start_d = 1'b1;
                if (cnt_q == 16'd1) begin
                    state_d = S_PAD;
                    cnt_d   = 16'(num_pads_q);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PAD: begin
                if (cnt_q == 16'd1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    tx_start_d = 1'b1;
                    cnt_d      = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            ndbps_q    <= '0;
            len_q      <= '0;
            tgt_q      <= '0;
            acc_q      <= '0;
            n_q        <= '0;
            n_sym_q    <= '0;
            num_pads_q <= '0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            sh_q       <= '0;
            byte_buf_q <= '0;
            buf_full_q <= 1'b0;
            fetched_q  <= '0;
            tx_start_q <= 1'b0;
            tx_x_q     <= 1'b0;
            done_q     <= 1'b0;
            rate_err_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ndbps_q    <= ndbps_d;
            len_q      <= len_d;
            tgt_q      <= tgt_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            n_sym_q    <= n_sym_d;
            num_pads_q <= num_pads_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            sh_q       <= sh_d;
            byte_buf_q <= byte_buf_d;
            buf_full_q <= buf_full_d;
            fetched_q  <= fetched_d;
            tx_start_q <= tx_start_d;
            tx_x_q     <= tx_x_d;
            done_q     <= done_d;
            rate_err_q <= rate_err_d;
            underrun_q <= underrun_d;
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign Tx_Start = tx_start_q;
    assign Tx_x     = tx_x_q;
    assign Num_Pads = num_pads_q;
    assign N_Sym    = n_sym_q;
    assign Done     = done_q;
    assign Rate_Err = rate_err_q;
    assign Underrun = underrun_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: hand-computed N_SYM/pad values and
// bench-built expected bit streams for each frame scenario.
module tb_tx_frame_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start_Frame;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic [7:0]  Data_In;
    logic        Data_Valid;
    logic        Data_Ready;
    logic        Tx_Start;
    logic        Tx_x;
    logic [7:0]  Num_Pads;
    logic [11:0] N_Sym;
    logic        Busy;
    logic        Done;
    logic        Rate_Err;
    logic        Underrun;

    tx_frame_sequencer #(.LEN_W(12)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start_Frame(Start_Frame),
        .Rate(Rate),
        .Length(Length),
        .Data_In(Data_In),
        .Data_Valid(Data_Valid),
        .Data_Ready(Data_Ready),
        .Tx_Start(Tx_Start),
        .Tx_x(Tx_x),
        .Num_Pads(Num_Pads),
        .N_Sym(N_Sym),
        .Busy(Busy),
        .Done(Done),
        .Rate_Err(Rate_Err),
        .Underrun(Underrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] src_mem [0:127];
    int src_idx, src_limit;
    int cyc, tx_cnt, first_tx, last_tx, n_done, n_under, n_err;
    int excl_viol = 0;
    bit stream [0:2047];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; tx_cnt = 0; first_tx = 0; last_tx = 0;
        n_done = 0; n_under = 0; n_err = 0; src_idx = 0;
    endtask

    // One clock: present the source byte, advance on transfer, record outputs at edge+1.
    task automatic step();
        logic xfer;
        Data_Valid = (src_idx < src_limit);
        Data_In    = src_mem[src_idx & 127];
        #0;
        xfer = Data_Valid && Data_Ready;
        @(posedge Clk);
        #1;
        if (xfer) src_idx++;
        cyc++;
        if (Tx_Start) begin
            if (tx_cnt == 0) first_tx = cyc;
            last_tx = cyc;
            if (tx_cnt < 2048) stream[tx_cnt] = Tx_x;
            tx_cnt++;
        end
        n_done  += int'(Done);
        n_under += int'(Underrun);
        n_err   += int'(Rate_Err);
        if ((int'(Done) + int'(Underrun) + int'(Rate_Err)) > 1) excl_viol++;
    endtask

    task automatic start(input logic [3:0] r, input int l);
        clear_stats();
        Rate = r;
        Length = 12'(l);
        Start_Frame = 1'b1;
        step();
        Start_Frame = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && n_under == 0 && k < budget) begin
            step();
            k++;
        end
        check({tag, "_ended"}, (n_done + n_under) != 0, 1);
    endtask

    task automatic check_stream(input string tag, input int len, input int pads, input int nbits);
        bit exp_bits [$];
        int mism = 0;
        repeat (16) exp_bits.push_back(1'b0);
        for (int i = 0; i < len; i++)
            for (int b = 0; b < 8; b++) exp_bits.push_back(src_mem[i][b]);
        repeat (6) exp_bits.push_back(1'b0);
        repeat (pads) exp_bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++)
            if (i < tx_cnt && i < 2048 && i < exp_bits.size() && stream[i] !== exp_bits[i]) mism++;
        check({tag, "_bits"}, tx_cnt, nbits);
        check({tag, "_stream_mism"}, mism, 0);
        check({tag, "_contig"}, last_tx - first_tx + 1, tx_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Start_Frame = 1'b0; Rate = '0; Length = '0;
        Data_In = '0; Data_Valid = 1'b0; src_limit = 0;
        clear_stats();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_txstart", Tx_Start, 0);
        check("rst_txx", Tx_x, 0);
        check("rst_nsym", N_Sym, 0);
        check("rst_pads", Num_Pads, 0);
        check("rst_flags", {Done, Rate_Err, Underrun, Data_Ready}, 0);
        Reset = 1'b0;
        step();
        check("idle_busy", Busy, 0);

        // 6 Mbps, 1 byte
        src_mem[0] = 8'hA5; src_limit = 1000;
        start(4'b1101, 1);
        check("A_busy", Busy, 1);
        wait_end("A", 500);
        check("A_done_now", Done, 1);
        check("A_busy_end", Busy, 0);
        check("A_nsym", N_Sym, 2);
        check("A_pads", Num_Pads, 18);
        check("A_first_tx", first_tx, 3);
        check("A_ndone", n_done, 1);
        check("A_nunder", n_under, 0);
        check_stream("A", 1, 18, 48);
        step();
        check("A_done_width", Done, 0);

        // 54 Mbps, 100 bytes
        for (int i = 0; i < 100; i++) src_mem[i] = 8'(i * 37 + 5);
        start(4'b0011, 100);
        wait_end("B", 3000);
        check("B_nsym", N_Sym, 4);
        check("B_pads", Num_Pads, 42);
        check("B_first_tx", first_tx, 5);
        check("B_bytes", src_idx, 100);
        check("B_nunder", n_under, 0);
        check_stream("B", 100, 42, 864);

        // invalid rate, then zero length
        start(4'b0000, 5);
        check("E1_err", Rate_Err, 1);
        check("E1_busy", Busy, 0);
        step();
        check("E1_err_width", Rate_Err, 0);
        repeat (4) step();
        check("E1_nerr", n_err, 1);
        check("E1_tx", tx_cnt, 0);
        start(4'b1101, 0);
        repeat (4) step();
        check("E2_nerr", n_err, 1);
        check("E2_busy", Busy, 0);
        check("E2_tx", tx_cnt, 0);

        // underrun after 2 of 4 bytes
        for (int i = 0; i < 4; i++) src_mem[i] = 8'h3C + 8'(i * 17);
        src_limit = 2;
        start(4'b1101, 4);
        wait_end("U", 500);
        check("U_under_now", Underrun, 1);
        check("U_txstart", Tx_Start, 0);
        check("U_busy", Busy, 0);
        check("U_ndone", n_done, 0);
        check_stream("U", 4, 0, 32);
        repeat (3) step();
        check("U_under_width", n_under, 1);
        check("U_ndone_after", n_done, 0);
        src_limit = 1000;

        // reset during TAIL, then a frame with an ignored request
        src_mem[0] = 8'h11; src_mem[1] = 8'hE2; src_mem[2] = 8'h5B;
        start(4'b1111, 3);
        for (int k = 0; k < 300 && tx_cnt < 42; k++) step();
        check("R_in_tail", tx_cnt, 42);
        #2 Reset = 1'b1;
        #1;
        check("R_busy", Busy, 0);
        check("R_txstart", Tx_Start, 0);
        check("R_nsym", N_Sym, 0);
        check("R_pads", Num_Pads, 0);
        check("R_ready", Data_Ready, 0);
        @(posedge Clk);
        #1;
        check("R_idle", Busy, 0);
        Reset = 1'b0;
        start(4'b1111, 3);
        begin
            int k = 0;
            while (n_done == 0 && n_under == 0 && k < 500) begin
                if (cyc == 20) begin
                    Start_Frame = 1'b1; Rate = 4'b1101; Length = 12'd1;
                end
                step();
                Start_Frame = 1'b0;
                k++;
            end
        end
        check("R2_ndone", n_done, 1);
        check("R2_nerr", n_err, 0);
        check("R2_nsym", N_Sym, 2);
        check("R2_pads", Num_Pads, 26);
        check_stream("R2", 3, 26, 72);

        // back-to-back frames
        src_mem[0] = 8'h81; src_mem[1] = 8'h7E;
        start(4'b0101, 2);
        wait_end("C1", 500);
        check("C1_done_now", Done, 1);
        check("C1_nsym", N_Sym, 1);
        check("C1_pads", Num_Pads, 10);
        check_stream("C1", 2, 10, 48);
        src_mem[0] = 8'hC3;
        start(4'b1101, 1);
        check("C2_busy", Busy, 1);
        wait_end("C2", 500);
        check("C2_nsym", N_Sym, 2);
        check("C2_pads", Num_Pads, 18);
        check("C2_first_tx", first_tx, 3);
        check_stream("C2", 1, 18, 48);

        check("flag_excl", excl_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Sequences one 802.11a DATA field into `Transmitter_2` (scrambler → convolutional encoder → interleaver). For each frame it takes a RATE code and PSDU length, computes N_SYM and the pad count, and feeds the transmitter one bit per cycle. The bit stream is the 16 SERVICE zeros, then the PSDU bytes (LSB first), then 6 tail zeros, then the pad zeros. It sits between the MAC byte source and the transmitter's `Start`/`x`/`num_pads` inputs.

## Interface
- `LEN_W`, default 12: PSDU length width in bytes.
- `Clk`  in  1: clock, rising edge.
- `Reset`  in  1: asynchronous, active-high; clears all state.
- `Start_Frame`  in  1: one-cycle frame request; sampled in IDLE only.
- `Rate`  in  4: 802.11a RATE code R1..R4; sampled with `Start_Frame`.
- `Length`  in  LEN_W: PSDU bytes, 1..4095; sampled with `Start_Frame`.
- `Data_In`  in  8: PSDU byte.
- `Data_Valid`  in  1: `Data_In` is valid.
- `Data_Ready`  out  1: the one-byte prefetch buffer can accept a byte.
- `Tx_Start`  out  1: drives transmitter `Start`; high for exactly N_SYM·N_DBPS cycles.
- `Tx_x`  out  1: drives transmitter `x`.
- `Num_Pads`  out  8: pad bit count; drives transmitter `num_pads` (low bits).
- `N_Sym`  out  LEN_W: OFDM symbol count of the current frame.
- `Busy`  out  1: high outside IDLE.
- `Done`  out  1: one-cycle pulse after the last pad bit.
- `Rate_Err`  out  1: one-cycle pulse when a request is rejected.
- `Underrun`  out  1: one-cycle pulse when a frame is aborted for lack of data.

## Operation
- **Reset values.** All outputs 0 and state IDLE. `Num_Pads`/`N_Sym` hold their last computed value until the next CALC.
- **Rate to N_DBPS.** 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216. Any other code, or `Length`==0, is rejected: `Rate_Err` pulses and the state stays IDLE.
- **States.** IDLE → CALC → SERVICE → DATA → TAIL → PAD → IDLE.
- **CALC.**
  - T = 22 + 8·Length, 16-bit.
  - Accumulator acc starts at 0 and n at 0; each cycle acc += N_DBPS and n += 1.
  - Exit when acc ≥ T: `N_Sym` = n and `Num_Pads` = acc − T, both registered on exit.
  - No divider. The worst case is 1366 cycles.
  - Pad is never 0, because T ≡ 6 (mod 8) and every N_DBPS is ≡ 0 or 4 (mod 8). Pad is always less than N_DBPS.
- **Bit phases.** `Tx_Start` is high throughout.
  - SERVICE: 16 zero bits.
  - DATA: 8·Length bits, taken from a shift register, LSB first.
  - TAIL: 6 zero bits.
  - PAD: `Num_Pads` zero bits.
  - Phase counters are 16-bit down-counters.
- **Byte path.**
  - `Data_Ready` = buffer empty AND state ∈ {CALC, SERVICE, DATA} AND bytes-fetched < Length.
  - A transfer occurs on `Data_Valid` && `Data_Ready`.
  - The shift register loads from the buffer on the cycle the first DATA bit is issued and after each 8th bit. A transfer into the buffer in that same cycle is allowed: the buffer is freed and refilled together.
- **Underrun.** If a byte load is due and the buffer is empty:
  - `Underrun` pulses, `Tx_Start` drops that cycle, and the state goes to IDLE.
  - No `Done` is issued.
  - Fetched bytes are discarded.
- **Requests while busy.** `Start_Frame` while `Busy` is ignored, with no error flag.
- **Completion.** After the last PAD bit: `Done` pulses, `Busy` falls, and the state is IDLE. A new `Start_Frame` in that same IDLE cycle is accepted.

## Timing
- **Start of frame.** `Start_Frame` at edge k → `Busy`=1 from k+1. CALC occupies n cycles. The first SERVICE bit has `Tx_Start`=1 in the cycle after CALC exit.
- **Output registering.** `Tx_x` and `Tx_Start` are registered outputs and change only on `Clk`.
- **Contiguous bit stream.** `Tx_Start` is never deasserted mid-frame except on underrun. Bits are contiguous from SERVICE through PAD, which the transmitter requires.
- **First byte deadline.** The first byte must be in the buffer by the last SERVICE bit. Each subsequent byte must arrive within 8 cycles of the previous load.
- **Output validity.** `Num_Pads` and `N_Sym` are stable from the first SERVICE bit until the next CALC exit.
- **Flag pulses.** `Done`, `Rate_Err` and `Underrun` are each exactly one cycle wide and mutually exclusive.
- **Reset during a frame.** Outputs clear immediately (asynchronously). The state returns to IDLE and the partial frame is dropped.

## Test plan
- **6 Mbps, 1 byte.** Rate=1101, Length=1, byte 0xA5 always valid → N_Sym=2 and Num_Pads=18. `Tx_Start` high for 48 cycles. Stream is 16×0, then 1,0,1,0,0,1,0,1, then 6×0, then 18×0. One `Done`.
- **54 Mbps, 100 bytes.** Rate=0011, Length=100 → N_Sym=4 and Num_Pads=42. 864 `Tx_Start` cycles. All 100 bytes are accepted in order with no `Underrun`.
- **Invalid request.** Rate=0000 (or Length=0) → `Rate_Err` single pulse. `Busy` stays 0 and `Tx_Start` never asserts.
- **Underrun.** Rate=1101, Length=4, source drops `Data_Valid` after 2 bytes → `Underrun` pulse at the bit-16 load of DATA. `Tx_Start` falls and there is no `Done`.
- **Reset and ignored request.** Rate=1111, Length=3: `Reset` asserted during TAIL → all outputs 0 and IDLE next cycle. The following frame (Rate=1111, Length=3) gives N_Sym=2 and Num_Pads=26. A `Start_Frame` during that frame is ignored.
- **Back-to-back frames.** `Start_Frame` in the cycle after `Done` → second frame accepted with no dead cycles beyond its CALC.
